store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 26 ++
 rtl/store_buffer_if.sv | 44 ++++
 rtl/store_buffer_fwd.sv | 33 +++
 rtl/store_buffer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types for the tartaruga store buffer.
// Entry layout, store sizes and buffer depth.
package tartaruga_pkg;

  localparam int STORE_BUFFER_SIZE = 4;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    FREE,
    PENDING,
    COMMITTED
  } sb_state_t;

  typedef struct packed {
    sb_state_t   state;
    logic [31:0] addr;
    logic [31:0] data;
    mem_size_t   size;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Allocate / commit / drain bundle of the store buffer.
// master = pipeline and memory side, slave = store buffer.
interface store_buffer_if
  import tartaruga_pkg::*;
#(
  parameter int SB_SIZE = STORE_BUFFER_SIZE
);
  localparam int IW = $clog2(SB_SIZE);

  logic          alloc_valid_i;
  logic [31:0]   alloc_addr_i;
  logic [31:0]   alloc_data_i;
  logic [1:0]    alloc_size_i;
  logic          alloc_ready_o;
  logic [IW-1:0] alloc_idx_o;
  logic          commit_valid_i;
  logic [IW-1:0] commit_idx_i;
  logic          mem_req_valid_o;
  logic [31:0]   mem_req_addr_o;
  logic [31:0]   mem_req_data_o;
  logic [1:0]    mem_req_size_o;
  logic          mem_req_ready_i;

  modport master (
    output alloc_valid_i, alloc_addr_i,
    output alloc_data_i, alloc_size_i,
    input  alloc_ready_o, alloc_idx_o,
    output commit_valid_i, commit_idx_i,
    input  mem_req_valid_o, mem_req_addr_o,
    input  mem_req_data_o, mem_req_size_o,
    output mem_req_ready_i
  );

  modport slave (
    input  alloc_valid_i, alloc_addr_i,
    input  alloc_data_i, alloc_size_i,
    output alloc_ready_o, alloc_idx_o,
    input  commit_valid_i, commit_idx_i,
    output mem_req_valid_o, mem_req_addr_o,
    output mem_req_data_o, mem_req_size_o,
    input  mem_req_ready_i
  );

endinterface

// File: rtl/store_buffer_fwd.sv
// Youngest exact-match store-to-load forwarding search.
// Walks entries oldest (head) to youngest so the last hit wins.
module store_buffer_fwd
  import tartaruga_pkg::*;
#(
  parameter int SB_SIZE = STORE_BUFFER_SIZE,
  localparam int IW = $clog2(SB_SIZE)
) (
  input  sb_entry_t     ent_i [SB_SIZE],
  input  logic [IW-1:0] head_i,
  input  logic [31:0]   ld_addr_i,
  input  logic [1:0]    ld_size_i,
  output logic          hit_o,
  output logic [31:0]   data_o
);

  always_comb begin
    logic [IW-1:0] idx;
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < SB_SIZE; k++) begin
      idx = head_i + IW'(k);
      if (ent_i[idx].state != FREE &&
          ent_i[idx].addr == ld_addr_i &&
          ent_i[idx].size == ld_size_i) begin
        hit_o  = 1'b1;
        data_o = ent_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between memory stage and data memory.
// Define STORE_BUFFER_FWD_EN to compile in load forwarding.
module store_buffer
  import tartaruga_pkg::*;
#(
  parameter int SB_SIZE = STORE_BUFFER_SIZE,
  localparam int IW = $clog2(SB_SIZE)
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  store_buffer_if.slave sb,
  input  logic         flush_i,
  input  logic [31:0]  ld_addr_i,
  input  logic [1:0]   ld_size_i,
  output logic         ld_hit_o,
  output logic [31:0]  ld_data_o,
  output logic         ld_conflict_o,
  output logic         empty_o
);

  localparam int CW = IW + 1;
  localparam logic [CW-1:0] FULL = CW'(SB_SIZE);

  sb_entry_t     ent_q [SB_SIZE];
  sb_entry_t     ent_d [SB_SIZE];
  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          alloc_fire;
  logic          drain_fire;
  logic          wconf;

  assign sb.alloc_ready_o = (cnt_q < FULL) && !flush_i;
  assign sb.alloc_idx_o   = tail_q;

  assign sb.mem_req_valid_o = ent_q[head_q].state == COMMITTED;
  assign sb.mem_req_addr_o  = ent_q[head_q].addr;
  assign sb.mem_req_data_o  = ent_q[head_q].data;
  assign sb.mem_req_size_o  = ent_q[head_q].size;

  assign alloc_fire = sb.alloc_valid_i && sb.alloc_ready_o;
  assign drain_fire = sb.mem_req_valid_o && sb.mem_req_ready_i;
  assign empty_o    = cnt_q == '0;

  always_comb begin
    logic [CW-1:0] ncm;
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    ncm    = '0;
    if (alloc_fire) begin
      ent_d[tail_q].state = PENDING;
      ent_d[tail_q].addr  = sb.alloc_addr_i;
      ent_d[tail_q].data  = sb.alloc_data_i;
      ent_d[tail_q].size  = mem_size_t'(sb.alloc_size_i);
      tail_d = tail_q + IW'(1);
    end
    if (sb.commit_valid_i &&
        ent_q[sb.commit_idx_i].state == PENDING)
      ent_d[sb.commit_idx_i].state = COMMITTED;
    if (drain_fire) begin
      ent_d[head_q].state = FREE;
      head_d = head_q + IW'(1);
    end
    cnt_d = cnt_q + CW'(alloc_fire) - CW'(drain_fire);
    // Flush sees the same-cycle commit; committed run starts at head.
    if (flush_i) begin
      for (int i = 0; i < SB_SIZE; i++) begin
        if (ent_d[i].state == PENDING)
          ent_d[i].state = FREE;
        if (ent_d[i].state == COMMITTED)
          ncm = ncm + CW'(1);
      end
      tail_d = head_d + ncm[IW-1:0];
      cnt_d  = ncm;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < SB_SIZE; i++)
        ent_q[i].state <= FREE;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ent_q  <= ent_d;
    end
  end

  always_comb begin
    wconf = 1'b0;
    for (int i = 0; i < SB_SIZE; i++)
      if (ent_q[i].state != FREE &&
          ent_q[i].addr[31:2] == ld_addr_i[31:2])
        wconf = 1'b1;
  end

`ifdef STORE_BUFFER_FWD_EN
  logic        fwd_hit;
  logic [31:0] fwd_data;

  store_buffer_fwd #(
    .SB_SIZE (SB_SIZE)
  ) u_fwd (
    .ent_i     (ent_q),
    .head_i    (head_q),
    .ld_addr_i (ld_addr_i),
    .ld_size_i (ld_size_i),
    .hit_o     (fwd_hit),
    .data_o    (fwd_data)
  );

  assign ld_hit_o      = fwd_hit;
  assign ld_data_o     = fwd_data;
  assign ld_conflict_o = wconf && !fwd_hit;
`else
  logic fwd_unused;
  assign fwd_unused    = ^{ld_size_i, ld_addr_i[1:0]};
  assign ld_hit_o      = 1'b0;
  assign ld_data_o     = '0;
  assign ld_conflict_o = wconf;
`endif

endmodule
